mine_placer: RTL and testbench

Parametrised successor to the fixed 5x5 mine-placement generator. Places exactly n_mines distinct mines on a ROWS x COLS board. Candidate cells come from the LCG X[n+1] = (mult*X[n] + incr) mod N, where N = ROWS*COLS. A candidate that collides with an existing mine, or with the optional safe cell, is resolved by linear probing. This guarantees termination and an exact mine count. The block sits between the game controller (start / place_done handshake) and the board state/neighbour-count logic (mines vector).

---
 rtl/mine_pkg.sv | 23 ++
 rtl/mine_lcg_step.sv | 23 ++
 rtl/mine_placer.sv | 166 ++++++++++++++++
 tb/tb_mine_placer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mine_pkg.sv
// Shared types and width helpers for the mine placement generator.
package mine_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GEN   = 2'd1,
    PROBE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DEF_ROWS = 5;
  localparam int DEF_COLS = 5;

  // Never return a zero width, so a degenerate 1-cell board still elaborates.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mine_lcg_step.sv
// One combinational LCG step: y = (a*x + c) mod N, evaluated at full product width.
module mine_lcg_step
  import mine_pkg::*;
#(
  parameter int N     = DEF_ROWS * DEF_COLS,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [IDX_W-1:0] a_i,
  input  logic [IDX_W-1:0] x_i,
  input  logic [IDX_W-1:0] c_i,
  output logic [IDX_W-1:0] y_o
);

  localparam int PW = 2 * IDX_W + 1;
  localparam logic [PW-1:0] MODULUS = PW'(N);

  logic [PW-1:0] sum;

  // a and x may both exceed N, so the product must not be truncated before the modulo.
  assign sum = (PW'(a_i) * PW'(x_i)) + PW'(c_i);
  assign y_o = IDX_W'(sum % MODULUS);

endmodule

// File: rtl/mine_placer.sv
// Places exactly n_mines distinct mines on a ROWS x COLS board using an LCG
// candidate sequence with linear probing around collisions and the safe cell.
module mine_placer
  import mine_pkg::*;
#(
  parameter  int ROWS  = DEF_ROWS,
  parameter  int COLS  = DEF_COLS,
  localparam int N     = ROWS * COLS,
  localparam int IDX_W = idx_w(N),
  localparam int CNT_W = cnt_w(N)
) (
  input  logic             clka,
  input  logic             restart_n,
  input  logic             start,
  input  logic [IDX_W-1:0] mult,
  input  logic [IDX_W-1:0] incr,
  input  logic [IDX_W-1:0] seed,
  input  logic             safe_en,
  input  logic [IDX_W-1:0] safe_idx,
  input  logic [CNT_W-1:0] n_mines,
  output logic             busy,
  output logic             place_done,
  output logic             err_cfg,
  output logic [N-1:0]     mines,
  output logic [CNT_W-1:0] mine_cnt,
  output logic [IDX_W-1:0] cur_index
);

  localparam logic [IDX_W:0]   N_EXT    = (IDX_W + 1)'(N);
  localparam logic [CNT_W:0]   N_CNT    = (CNT_W + 1)'(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_e           state_q, state_d;
  logic [N-1:0]     mines_q, mines_d;
  logic [CNT_W-1:0] mineCnt_q, mineCnt_d;
  logic [IDX_W-1:0] curIdx_q, curIdx_d;
  logic [IDX_W-1:0] mult_q, mult_d;
  logic [IDX_W-1:0] incr_q, incr_d;
  logic             safeEn_q, safeEn_d;
  logic [IDX_W-1:0] safeIdx_q, safeIdx_d;
  logic [CNT_W-1:0] nMines_q, nMines_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] lcgNext;
  logic [IDX_W-1:0] probeNext;
  logic [IDX_W-1:0] seedModN;
  logic [CNT_W:0]   maxMines;
  logic             cfgLegal;
  logic             blocked;
  logic [CNT_W-1:0] cntInc;

  mine_lcg_step #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_lcg (
    .a_i (mult_q),
    .x_i (curIdx_q),
    .c_i (incr_q),
    .y_o (lcgNext)
  );

  // The safe cell removes one free slot, so it lowers the legal mine ceiling.
  assign maxMines  = N_CNT - {{CNT_W{1'b0}}, safe_en};
  assign cfgLegal  = ({1'b0, n_mines} <= maxMines) &&
                     !(safe_en && ({1'b0, safe_idx} >= N_EXT));
  assign seedModN  = IDX_W'({1'b0, seed} % N_EXT);
  assign probeNext = (curIdx_q == LAST_IDX) ? '0 : curIdx_q + IDX_W'(1);
  assign blocked   = mines_q[curIdx_q] || (safeEn_q && (curIdx_q == safeIdx_q));
  assign cntInc    = mineCnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    mines_d   = mines_q;
    mineCnt_d = mineCnt_q;
    curIdx_d  = curIdx_q;
    mult_d    = mult_q;
    incr_d    = incr_q;
    safeEn_d  = safeEn_q;
    safeIdx_d = safeIdx_q;
    nMines_d  = nMines_q;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (cfgLegal) begin
            mult_d    = mult;
            incr_d    = incr;
            safeEn_d  = safe_en;
            safeIdx_d = safe_idx;
            nMines_d  = n_mines;
            mines_d   = '0;
            mineCnt_d = '0;
            curIdx_d  = seedModN;
            state_d   = (n_mines == '0) ? DONE : GEN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      GEN: begin
        curIdx_d = lcgNext;
        state_d  = PROBE;
      end
      PROBE: begin
        if (blocked) begin
          curIdx_d = probeNext;
        end else begin
          mines_d[curIdx_q] = 1'b1;
          mineCnt_d         = cntInc;
          state_d           = (cntInc == nMines_q) ? DONE : GEN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are registered from the next state so they line up with it.
    busy_d = (state_d == GEN) || (state_d == PROBE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state_q   <= IDLE;
      mines_q   <= '0;
      mineCnt_q <= '0;
      curIdx_q  <= '0;
      mult_q    <= '0;
      incr_q    <= '0;
      safeEn_q  <= 1'b0;
      safeIdx_q <= '0;
      nMines_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mines_q   <= mines_d;
      mineCnt_q <= mineCnt_d;
      curIdx_q  <= curIdx_d;
      mult_q    <= mult_d;
      incr_q    <= incr_d;
      safeEn_q  <= safeEn_d;
      safeIdx_q <= safeIdx_d;
      nMines_q  <= nMines_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign busy       = busy_q;
  assign place_done = done_q;
  assign err_cfg    = err_q;
  assign mines      = mines_q;
  assign mine_cnt   = mineCnt_q;
  assign cur_index  = curIdx_q;

endmodule

// File: tb/tb_mine_placer.sv
// Scoreboard bench for mine_placer on a 5x5 board: a reference model predicts
// the final board, count and latency of every request; a monitor checks each pulse.
module tb_mine_placer;

  localparam int N = 25;

  logic        clka = 1'b0;
  logic        restart_n;
  logic        start;
  logic [4:0]  mult, incr, seed, safe_idx;
  logic        safe_en;
  logic [4:0]  n_mines;
  logic        busy, place_done, err_cfg;
  logic [24:0] mines;
  logic [4:0]  mine_cnt;
  logic [4:0]  cur_index;

  always #5 clka = ~clka;

  mine_placer #(.ROWS(5), .COLS(5)) dut (
    .clka       (clka),
    .restart_n  (restart_n),
    .start      (start),
    .mult       (mult),
    .incr       (incr),
    .seed       (seed),
    .safe_en    (safe_en),
    .safe_idx   (safe_idx),
    .n_mines    (n_mines),
    .busy       (busy),
    .place_done (place_done),
    .err_cfg    (err_cfg),
    .mines      (mines),
    .mine_cnt   (mine_cnt),
    .cur_index  (cur_index)
  );

  typedef struct {
    string       name;
    bit          isErr;
    logic [24:0] mines;
    int          cnt;
    int          lat;
    int          driveCyc;
  } exp_t;

  exp_t        sbQ[$];
  exp_t        monE;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [24:0] modelMines = '0;
  int          modelCnt = 0;

  always @(posedge clka) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk the LCG with plain integer arithmetic, skipping occupied or safe cells.
  function automatic bit modelPlace(input int m, input int inc, input int sd, input int se,
                                    input int si, input int n, output int probes);
    int x;
    probes = 0;
    if ((n > N - se) || ((se != 0) && (si >= N))) return 1'b1;
    modelMines = '0;
    x = sd % N;
    for (int k = 0; k < n; k++) begin
      x = (m * x + inc) % N;
      while (modelMines[x] || ((se != 0) && (x == si))) begin
        x = (x + 1) % N;
        probes++;
      end
      modelMines[x] = 1'b1;
    end
    modelCnt = n;
    return 1'b0;
  endfunction

  always @(negedge clka) begin
    if (restart_n && (place_done || err_cfg)) begin
      if (sbQ.size() == 0) begin
        checkOutput("spuriousPulse", {62'd0, place_done, err_cfg}, 64'd0);
      end else begin
        monE = sbQ.pop_front();
        checkOutput({monE.name, ":kind"}, {62'd0, place_done, err_cfg},
                    monE.isErr ? 64'd1 : 64'd2);
        checkOutput({monE.name, ":mines"}, 64'(mines), 64'(monE.mines));
        checkOutput({monE.name, ":cnt"}, 64'(mine_cnt), 64'(monE.cnt));
        checkOutput({monE.name, ":latency"}, 64'(cyc - monE.driveCyc), 64'(monE.lat));
        checkOutput({monE.name, ":busyLow"}, 64'(busy), 64'd0);
      end
    end
  end

  task automatic applyStimulus(input string name, input int m, input int inc, input int sd,
                               input int se, input int si, input int n, input bit pushExp);
    exp_t e;
    int   probes;
    bit   isErr;
    @(negedge clka);
    mult     = 5'(m);
    incr     = 5'(inc);
    seed     = 5'(sd);
    safe_en  = 1'(se);
    safe_idx = 5'(si);
    n_mines  = 5'(n);
    start    = 1'b1;
    isErr    = modelPlace(m, inc, sd, se, si, n, probes);
    e.name     = name;
    e.isErr    = isErr;
    e.mines    = modelMines;
    e.cnt      = modelCnt;
    e.lat      = isErr ? 1 : 2 * n + 1 + probes;
    e.driveCyc = cyc;
    if (pushExp) sbQ.push_back(e);
    @(posedge clka);
    @(negedge clka);
    start = 1'b0;
    if (!isErr && n > 0) checkOutput({name, ":busyHigh"}, 64'(busy), 64'd1);
  endtask

  // Inputs are scrambled while waiting to show the configuration is latched.
  task automatic waitIdle(input string name);
    for (int i = 0; i < 1000 && sbQ.size() != 0; i++) begin
      @(negedge clka);
      mult     = 5'($urandom);
      incr     = 5'($urandom);
      seed     = 5'($urandom);
      safe_en  = 1'($urandom);
      safe_idx = 5'($urandom);
      n_mines  = 5'($urandom);
    end
    if (sbQ.size() != 0) begin
      checkOutput({name, ":timeout"}, 64'(sbQ.size()), 64'd0);
      sbQ.delete();
    end
  endtask

  initial begin
    restart_n = 1'b0;
    start     = 1'b0;
    mult      = '0;
    incr      = '0;
    seed      = '0;
    safe_en   = 1'b0;
    safe_idx  = '0;
    n_mines   = '0;
    repeat (3) @(negedge clka);
    checkOutput("reset:mines", 64'(mines), 64'd0);
    checkOutput("reset:cnt", 64'(mine_cnt), 64'd0);
    checkOutput("reset:index", 64'(cur_index), 64'd0);
    checkOutput("reset:flags", {61'd0, busy, place_done, err_cfg}, 64'd0);
    restart_n = 1'b1;

    applyStimulus("basic", 1, 3, 0, 0, 0, 3, 1'b1);
    waitIdle("basic");
    checkOutput("basic:const", 64'(mines), 64'h248);

    applyStimulus("collide", 0, 4, 0, 0, 0, 3, 1'b1);
    waitIdle("collide");
    checkOutput("collide:const", 64'(mines), 64'h70);

    applyStimulus("safe", 1, 3, 0, 1, 6, 3, 1'b1);
    waitIdle("safe");
    checkOutput("safe:const", 64'(mines), 64'h488);

    applyStimulus("wrap", 0, 24, 0, 0, 0, 2, 1'b1);
    waitIdle("wrap");
    checkOutput("wrap:const", 64'(mines), 64'h1000001);

    applyStimulus("zero", 7, 5, 9, 0, 0, 0, 1'b1);
    waitIdle("zero");
    checkOutput("zero:const", 64'(mines), 64'd0);

    applyStimulus("basic2", 1, 3, 0, 0, 0, 3, 1'b1);
    waitIdle("basic2");
    applyStimulus("illegalCnt", 1, 3, 0, 1, 0, 25, 1'b1);
    waitIdle("illegalCnt");
    checkOutput("illegalCnt:kept", 64'(mines), 64'h248);
    applyStimulus("illegalSafe", 1, 3, 0, 1, 27, 1, 1'b1);
    waitIdle("illegalSafe");
    applyStimulus("illegal26", 1, 3, 0, 0, 0, 26, 1'b1);
    waitIdle("illegal26");
    applyStimulus("full", 1, 3, 0, 0, 0, 25, 1'b1);
    waitIdle("full");
    checkOutput("full:const", 64'(mines), 64'h1FFFFFF);

    applyStimulus("abort", 1, 3, 0, 0, 0, 3, 1'b0);
    repeat (3) @(posedge clka);
    @(negedge clka);
    checkOutput("abort:preCnt", 64'(mine_cnt), 64'd1);
    restart_n = 1'b0;
    #1;
    checkOutput("abort:mines", 64'(mines), 64'd0);
    checkOutput("abort:cnt", 64'(mine_cnt), 64'd0);
    checkOutput("abort:flags", {61'd0, busy, place_done, err_cfg}, 64'd0);
    repeat (2) @(negedge clka);
    restart_n  = 1'b1;
    modelMines = '0;
    modelCnt   = 0;
    repeat (20) @(negedge clka);
    applyStimulus("rerun", 1, 3, 0, 0, 0, 3, 1'b1);
    waitIdle("rerun");
    checkOutput("rerun:const", 64'(mines), 64'h248);

    for (int t = 0; t < 40; t++) begin
      applyStimulus("rand", $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                    $urandom_range(0, 1), $urandom_range(0, 27), $urandom_range(0, 25), 1'b1);
      waitIdle("rand");
    end

    repeat (3) @(negedge clka);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
